// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-input scanning multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int DWELL_W = 8;

    // Index width that stays at least one bit wide for tiny channel counts.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Bus bundle between the channel sources/controller and the scanning multiplexer.
interface mux_nx1_scan_if
    import mux_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
);
    localparam int SELW = idx_width(N);

    logic [N*W-1:0]     IN;
    logic [SELW-1:0]    SEL;
    logic               MODE;
    logic               EN;
    logic [N-1:0]       CH_EN;
    logic [DWELL_W-1:0] DWELL;
    logic [W-1:0]       OUT;
    logic [SELW-1:0]    OUT_CH;
    logic               OUT_VALID;

    modport master (
        output IN, SEL, MODE, EN, CH_EN, DWELL,
        input  OUT, OUT_CH, OUT_VALID
    );

    modport slave (
        input  IN, SEL, MODE, EN, CH_EN, DWELL,
        output OUT, OUT_CH, OUT_VALID
    );

endinterface

// File: rtl/rr_next_ch.sv
// Combinational round-robin search: next set mask bit strictly after cur, wrapping.
// The current index itself is the last candidate, so a lone enabled channel re-selects itself.
module rr_next_ch
    import mux_pkg::*;
#(
    parameter int N    = 16,
    parameter int SELW = idx_width(N)
) (
    input  logic [N-1:0]    mask,
    input  logic [SELW-1:0] cur,
    output logic [SELW-1:0] nxt,
    output logic            found
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int  idx;
            logic hit;
            idx   = (int'(cur) + k) % N;
            hit   = mask[idx];
            nxt   = hit ? SELW'(idx) : nxt;
            found = found | hit;
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-input, W-bit registered multiplexer with manual select and round-robin auto-scan
// over enabled channels, each held for a programmable dwell time.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    mux_nx1_scan_if.slave bus
);

    localparam int             SELW  = idx_width(N);
    localparam logic [SELW:0]  N_IDX = (SELW + 1)'(N);

    logic [W-1:0]       out_q,       out_d;
    logic [SELW-1:0]    out_ch_q,    out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic [SELW-1:0]    ptr_q,       ptr_d;
    logic [DWELL_W-1:0] dwell_q,     dwell_d;
    mode_e              prev_mode_q, prev_mode_d;

    mode_e              mode_s;
    logic               scan_entry_s;
    logic               sel_oob_s;
    logic [SELW-1:0]    scan_ptr_s;
    logic [DWELL_W-1:0] dwell_lim_s;
    logic [SELW-1:0]    nxt_idx_s;
    logic               nxt_found_s;
    logic [SELW-1:0]    low_idx_s;
    logic               low_found_s;

    function automatic logic [W-1:0] pick_ch(input logic [N*W-1:0] flat,
                                             input logic [SELW-1:0] idx);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc | ({W{SELW'(k) == idx}} & flat[k*W +: W]);
        end
        return acc;
    endfunction

    rr_next_ch #(.N(N), .SELW(SELW)) u_next (
        .mask  (bus.CH_EN),
        .cur   (ptr_q),
        .nxt   (nxt_idx_s),
        .found (nxt_found_s)
    );

    // Searching after N-1 yields the lowest enabled channel.
    rr_next_ch #(.N(N), .SELW(SELW)) u_lowest (
        .mask  (bus.CH_EN),
        .cur   (SELW'(N - 1)),
        .nxt   (low_idx_s),
        .found (low_found_s)
    );

    assign mode_s       = mode_e'(bus.MODE);
    assign scan_entry_s = bus.EN && (mode_s == MODE_SCAN) && (prev_mode_q == MODE_MANUAL);
    assign scan_ptr_s   = scan_entry_s ? (low_found_s ? low_idx_s : '0) : ptr_q;
    assign dwell_lim_s  = (bus.DWELL == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                                                        : bus.DWELL - DWELL_W'(1);
    assign sel_oob_s    = ({1'b0, bus.SEL} >= N_IDX);

    // Next-state logic for output registers, scan pointer, dwell counter and mode history.
    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        ptr_d       = ptr_q;
        dwell_d     = dwell_q;
        prev_mode_d = prev_mode_q;
        if (!bus.EN) begin
            out_valid_d = 1'b0;
        end else if (mode_s == MODE_MANUAL) begin
            prev_mode_d = MODE_MANUAL;
            out_ch_d    = bus.SEL;
            if (sel_oob_s) begin
                out_d       = '0;
                out_valid_d = 1'b0;
            end else begin
                out_d       = pick_ch(bus.IN, bus.SEL);
                out_valid_d = 1'b1;
            end
        end else begin
            prev_mode_d = MODE_SCAN;
            out_d       = pick_ch(bus.IN, scan_ptr_s);
            out_ch_d    = scan_ptr_s;
            out_valid_d = bus.CH_EN[scan_ptr_s];
            // >= rather than == so a DWELL shrunk below the running count still advances.
            if (scan_entry_s) begin
                ptr_d   = scan_ptr_s;
                dwell_d = '0;
            end else if (bus.CH_EN == '0) begin
                dwell_d = '0;
            end else if (!bus.CH_EN[ptr_q] || (dwell_q >= dwell_lim_s)) begin
                ptr_d   = nxt_found_s ? nxt_idx_s : ptr_q;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            dwell_q     <= '0;
            prev_mode_q <= MODE_MANUAL;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            dwell_q     <= dwell_d;
            prev_mode_q <= prev_mode_d;
        end
    end

    assign bus.OUT       = out_q;
    assign bus.OUT_CH    = out_ch_q;
    assign bus.OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed testbench for mux_nx1_scan: a 16-channel instance for all features and a
// 12-channel instance for the out-of-range manual select.
module tb_mux_nx1_scan;

    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_errors;

    mux_nx1_scan_if #(.N(16), .W(8)) bus16 ();
    mux_nx1_scan_if #(.N(12), .W(8)) bus12 ();

    mux_nx1_scan #(.N(16), .W(8)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus16)
    );

    mux_nx1_scan #(.N(12), .W(8)) u_dut12 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus12)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus16.EN = 1'b1;
        bus16.MODE = 1'b0;
        bus16.SEL = 4'd3;
        tick();
        tick();
        if (bus16.OUT !== 8'h00) begin
            $display("FAIL reset_out: got %0h expected 0", bus16.OUT); n_errors++;
        end
        n_checks++;
        if (bus16.OUT_CH !== 4'd0) begin
            $display("FAIL reset_ch: got %0d expected 0", bus16.OUT_CH); n_errors++;
        end
        n_checks++;
        if (bus16.OUT_VALID !== 1'b0) begin
            $display("FAIL reset_valid: got %0b expected 0", bus16.OUT_VALID); n_errors++;
        end
        n_checks++;
        RST_N = 1'b1;
    endtask

    task automatic test_manual();
        bus16.EN = 1'b1;
        bus16.MODE = 1'b0;
        for (int s = 0; s < 16; s++) begin
            bus16.SEL = 4'(s);
            if (s > 0) begin
                if (bus16.OUT !== 8'(s - 1 + 16)) begin
                    $display("FAIL man_latency[%0d]: got %0h expected %0h", s, bus16.OUT, s - 1 + 16);
                    n_errors++;
                end
                n_checks++;
            end
            tick();
            if (bus16.OUT !== 8'(s + 16)) begin
                $display("FAIL man_out[%0d]: got %0h expected %0h", s, bus16.OUT, s + 16); n_errors++;
            end
            n_checks++;
            if (bus16.OUT_CH !== 4'(s)) begin
                $display("FAIL man_ch[%0d]: got %0d expected %0d", s, bus16.OUT_CH, s); n_errors++;
            end
            n_checks++;
            if (bus16.OUT_VALID !== 1'b1) begin
                $display("FAIL man_valid[%0d]: got %0b expected 1", s, bus16.OUT_VALID); n_errors++;
            end
            n_checks++;
        end
        bus12.EN = 1'b1;
        bus12.MODE = 1'b0;
        bus12.SEL = 4'd11;
        tick();
        if (bus12.OUT !== 8'h1B || bus12.OUT_VALID !== 1'b1) begin
            $display("FAIL n12_sel11: got %0h/%0b expected 1b/1", bus12.OUT, bus12.OUT_VALID); n_errors++;
        end
        n_checks++;
        bus12.SEL = 4'd13;
        tick();
        if (bus12.OUT !== 8'h00 || bus12.OUT_VALID !== 1'b0 || bus12.OUT_CH !== 4'd13) begin
            $display("FAIL n12_sel13: got %0h/%0b/%0d expected 0/0/13",
                     bus12.OUT, bus12.OUT_VALID, bus12.OUT_CH); n_errors++;
        end
        n_checks++;
        bus12.SEL = 4'd12;
        tick();
        if (bus12.OUT !== 8'h00 || bus12.OUT_VALID !== 1'b0 || bus12.OUT_CH !== 4'd12) begin
            $display("FAIL n12_sel12: got %0h/%0b/%0d expected 0/0/12",
                     bus12.OUT, bus12.OUT_VALID, bus12.OUT_CH); n_errors++;
        end
        n_checks++;
        bus12.EN = 1'b0;
    endtask

    task automatic test_scan_rr();
        int exp_a [14] = '{0, 0, 0, 0, 2, 2, 2, 5, 5, 5, 0, 0, 0, 2};
        int exp_b [6]  = '{2, 5, 0, 2, 5, 0};
        bus16.CH_EN = 16'h0025;
        bus16.DWELL = 8'd3;
        bus16.MODE = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus16.OUT_CH !== 4'(exp_a[i]) || bus16.OUT !== 8'(exp_a[i] + 16)
                || bus16.OUT_VALID !== 1'b1) begin
                $display("FAIL rr_dwell3[%0d]: got ch %0d out %0h v %0b expected ch %0d out %0h v 1",
                         i, bus16.OUT_CH, bus16.OUT, bus16.OUT_VALID, exp_a[i], exp_a[i] + 16);
                n_errors++;
            end
            n_checks++;
        end
        bus16.DWELL = 8'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus16.OUT_CH !== 4'(exp_b[i]) || bus16.OUT_VALID !== 1'b1) begin
                $display("FAIL rr_dwell0[%0d]: got ch %0d v %0b expected ch %0d v 1",
                         i, bus16.OUT_CH, bus16.OUT_VALID, exp_b[i]);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    task automatic test_mask_edge();
        int exp_ch [10] = '{3, 5, 5, 5, 0, 0, 0, 2, 2, 5};
        int exp_v  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        bus16.CH_EN = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus16.OUT_CH !== 4'd2 || bus16.OUT_VALID !== 1'b0) begin
                $display("FAIL mask_zero[%0d]: got ch %0d v %0b expected ch 2 v 0",
                         i, bus16.OUT_CH, bus16.OUT_VALID);
                n_errors++;
            end
            n_checks++;
        end
        bus16.CH_EN = 16'h0008;
        tick();
        if (bus16.OUT_CH !== 4'd2 || bus16.OUT_VALID !== 1'b0) begin
            $display("FAIL mask_single_first: got ch %0d v %0b expected ch 2 v 0",
                     bus16.OUT_CH, bus16.OUT_VALID);
            n_errors++;
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus16.OUT_CH !== 4'd3 || bus16.OUT !== 8'h13 || bus16.OUT_VALID !== 1'b1) begin
                $display("FAIL mask_single[%0d]: got ch %0d out %0h v %0b expected ch 3 out 13 v 1",
                         i, bus16.OUT_CH, bus16.OUT, bus16.OUT_VALID);
                n_errors++;
            end
            n_checks++;
        end
        bus16.CH_EN = 16'h0025;
        bus16.DWELL = 8'd3;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) bus16.CH_EN = 16'h0021;
            tick();
            if (bus16.OUT_CH !== 4'(exp_ch[i]) || bus16.OUT_VALID !== 1'(exp_v[i])) begin
                $display("FAIL mask_clear[%0d]: got ch %0d v %0b expected ch %0d v %0d",
                         i, bus16.OUT_CH, bus16.OUT_VALID, exp_ch[i], exp_v[i]);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    task automatic test_en_freeze();
        int exp_ch [6] = '{5, 5, 0, 0, 0, 2};
        bus16.CH_EN = 16'h0025;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus16.OUT_CH !== 4'(exp_ch[i])) begin
                $display("FAIL freeze_lead[%0d]: got ch %0d expected %0d", i, bus16.OUT_CH, exp_ch[i]);
                n_errors++;
            end
            n_checks++;
        end
        bus16.EN = 1'b0;
        bus16.IN[2*8 +: 8] = 8'hA2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus16.OUT_CH !== 4'd2 || bus16.OUT !== 8'h12 || bus16.OUT_VALID !== 1'b0) begin
                $display("FAIL freeze_hold[%0d]: got ch %0d out %0h v %0b expected ch 2 out 12 v 0",
                         i, bus16.OUT_CH, bus16.OUT, bus16.OUT_VALID);
                n_errors++;
            end
            n_checks++;
        end
        bus16.EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus16.OUT_CH !== ((i < 2) ? 4'd2 : 4'd5) || bus16.OUT !== ((i < 2) ? 8'hA2 : 8'h15)
                || bus16.OUT_VALID !== 1'b1) begin
                $display("FAIL freeze_resume[%0d]: got ch %0d out %0h v %0b",
                         i, bus16.OUT_CH, bus16.OUT, bus16.OUT_VALID);
                n_errors++;
            end
            n_checks++;
        end
        bus16.IN[2*8 +: 8] = 8'h12;
    endtask

    task automatic test_mode_switch();
        bus16.MODE = 1'b0;
        bus16.SEL = 4'd7;
        tick();
        if (bus16.OUT !== 8'h17 || bus16.OUT_CH !== 4'd7 || bus16.OUT_VALID !== 1'b1) begin
            $display("FAIL mode_manual7: got %0h/%0d/%0b expected 17/7/1",
                     bus16.OUT, bus16.OUT_CH, bus16.OUT_VALID); n_errors++;
        end
        n_checks++;
        bus16.MODE = 1'b1;
        bus16.CH_EN = 16'h0090;
        tick();
        if (bus16.OUT !== 8'h14 || bus16.OUT_CH !== 4'd4 || bus16.OUT_VALID !== 1'b1) begin
            $display("FAIL mode_entry: got %0h/%0d/%0b expected 14/4/1",
                     bus16.OUT, bus16.OUT_CH, bus16.OUT_VALID); n_errors++;
        end
        n_checks++;
        bus16.MODE = 1'b0;
        bus16.SEL = 4'd9;
        tick();
        if (bus16.OUT !== 8'h19 || bus16.OUT_CH !== 4'd9 || bus16.OUT_VALID !== 1'b1) begin
            $display("FAIL mode_exit: got %0h/%0d/%0b expected 19/9/1",
                     bus16.OUT, bus16.OUT_CH, bus16.OUT_VALID); n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_async_reset();
        int exp_ch [4] = '{0, 0, 1, 2};
        bus16.MODE = 1'b1;
        bus16.CH_EN = 16'h0025;
        bus16.DWELL = 8'd3;
        for (int i = 0; i < 8; i++) tick();
        if (bus16.OUT_CH !== 4'd5 || bus16.OUT !== 8'h15) begin
            $display("FAIL areset_setup: got ch %0d out %0h expected ch 5 out 15", bus16.OUT_CH, bus16.OUT);
            n_errors++;
        end
        n_checks++;
        #2;
        RST_N = 1'b0;
        #1;
        if (bus16.OUT !== 8'h00 || bus16.OUT_CH !== 4'd0 || bus16.OUT_VALID !== 1'b0) begin
            $display("FAIL areset_immediate: got %0h/%0d/%0b expected 0/0/0",
                     bus16.OUT, bus16.OUT_CH, bus16.OUT_VALID); n_errors++;
        end
        n_checks++;
        tick();
        RST_N = 1'b1;
        bus16.CH_EN = 16'hFFFF;
        bus16.DWELL = 8'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus16.OUT_CH !== 4'(exp_ch[i]) || bus16.OUT !== 8'(exp_ch[i] + 16)
                || bus16.OUT_VALID !== 1'b1) begin
                $display("FAIL areset_restart[%0d]: got ch %0d out %0h v %0b expected ch %0d",
                         i, bus16.OUT_CH, bus16.OUT, bus16.OUT_VALID, exp_ch[i]);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        CLK = 1'b0;
        RST_N = 1'b0;
        for (int k = 0; k < 16; k++) bus16.IN[k*8 +: 8] = 8'(k + 16);
        for (int k = 0; k < 12; k++) bus12.IN[k*8 +: 8] = 8'(k + 16);
        bus16.SEL = 4'd0;
        bus16.MODE = 1'b0;
        bus16.EN = 1'b0;
        bus16.CH_EN = 16'h0000;
        bus16.DWELL = 8'd0;
        bus12.SEL = 4'd0;
        bus12.MODE = 1'b0;
        bus12.EN = 1'b0;
        bus12.CH_EN = 12'h000;
        bus12.DWELL = 8'd0;

        test_reset();
        test_manual();
        test_scan_rr();
        test_mask_edge();
        test_en_freeze();
        test_mode_switch();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised N-input, W-bit registered multiplexer. Successor of the fixed 16x1 single-bit tree mux.
- Adds a one-cycle registered output path and two modes:
  - manual select;
  - auto-scan, which walks the enabled channels round-robin, holding each one for a programmable dwell time.
- Feeds the sampled-channel readout and monitor paths, where one shared consumer services many sources.

Parameters:
- N, 16, number of input channels (2..64)
- W, 8, data width per channel
- SELW, $clog2(N), channel index width (derived; do not override)

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN  input  N*W  flattened channel data; channel k occupies IN[k*W +: W]
- SEL  input  SELW  channel index, used in manual mode
- MODE  input  1  0 = manual, 1 = scan
- EN  input  1  global enable; 0 freezes all state
- CH_EN  input  N  per-channel enable mask, used in scan mode only
- DWELL  input  8  cycles per channel in scan mode; 0 is treated as 1
- OUT  output  W  registered selected data
- OUT_CH  output  SELW  index of the channel currently on OUT
- OUT_VALID  output  1  OUT/OUT_CH are meaningful this cycle

Behaviour:
- Reset (RST_N=0, asynchronous):
  - OUT, OUT_CH, OUT_VALID all go to 0.
  - Scan pointer and dwell counter go to 0.
  - prev_mode goes to 0.
  - Release is synchronous to CLK.
- Latency: exactly 1 cycle from IN/SEL sampled at edge t to OUT at edge t+1.
- EN=0:
  - OUT and OUT_CH hold; OUT_VALID <= 0.
  - Pointer, dwell counter and prev_mode are frozen.
- Manual mode (MODE=0, EN=1), each cycle:
  - OUT <= IN[SEL], OUT_CH <= SEL, OUT_VALID <= 1.
  - If SEL >= N: OUT <= 0, OUT_CH <= SEL, OUT_VALID <= 0.
  - CH_EN is ignored in this mode.
- Scan mode (MODE=1, EN=1):
  - Each cycle: OUT <= IN[ptr], OUT_CH <= ptr, OUT_VALID <= CH_EN[ptr].
  - Dwell counter increments each cycle. When it reaches max(DWELL,1)-1, the counter clears and ptr advances to the next enabled channel strictly after ptr, searching upward and wrapping N-1 -> 0.
  - If ptr is the only enabled channel, ptr stays put.
  - If CH_EN == 0: ptr holds, OUT_VALID <= 0, dwell counter held at 0.
  - If CH_EN[ptr] is cleared mid-dwell: OUT_VALID <= 0 the next cycle, and ptr advances on the following cycle regardless of dwell count.
- Mode entry (prev_mode=0, MODE=1, EN=1):
  - ptr loads the lowest enabled channel (0 if none enabled); dwell counter clears.
  - The output on that edge follows the scan rule using the new ptr.
- Mode exit (MODE 1 -> 0): manual rule applies immediately; ptr is retained but not used.
- DWELL or CH_EN changing mid-scan takes effect from the next cycle's comparison. No restart.
- Width rules:
  - The dwell counter is 8 bits, compared against DWELL-1 (DWELL=0 -> 0).
  - ptr is SELW bits; wrap is explicit at N-1, so non-power-of-2 N never reaches an index >= N.
- Simultaneous events: reset dominates everything; EN=0 dominates a mode change. The mode transition is detected only when EN=1.

Decomposition:
- Package mux_pkg:
  - typedef mode_e {MODE_MANUAL, MODE_SCAN};
  - constant DWELL_W = 8;
  - function for clog2-safe index width.
- One sub-module: rr_next_ch (combinational). Given mask[N] and the current index, it returns the next set index strictly after the current one, with wrap and a found flag. It is also used for "lowest enabled" by passing current = N-1.

Test Plan:
- Reset: assert RST_N=0 mid-scan at ptr=5 -> OUT=0, OUT_CH=0, OUT_VALID=0 immediately, without waiting for CLK; after release with MODE=1, CH_EN=all ones, scan restarts from channel 0.
- Manual: N=16, W=8, IN[k]=k+0x10, SEL swept 0..15 -> OUT one cycle later = SEL+0x10, OUT_CH=SEL, OUT_VALID=1; with N=12, SEL=13 -> OUT=0, VALID=0.
- Scan round-robin: CH_EN=0x0025 (ch 0,2,5), DWELL=3 -> OUT_CH sequence 0,0,0,2,2,2,5,5,5,0..., VALID=1 throughout; DWELL=0 -> channel changes every cycle.
- Mask edge: CH_EN=0 -> OUT_VALID=0, ptr stuck; CH_EN=0x0008 only -> OUT_CH=3 continuously. Clear CH_EN[2] mid-dwell on ch 2 -> VALID drops next cycle, then OUT_CH=5.
- EN freeze: EN=0 for 4 cycles during scan at ch 2, dwell count 1 -> OUT/OUT_CH hold, VALID=0; on resume, ch 2 completes its remaining 2 cycles before advancing.
- Mode switch: manual SEL=7, then MODE=1 with CH_EN=0x0090 -> first scan output is ch 4; switching back to MODE=0 -> OUT=IN[SEL] on the next edge.
